// File: rtl/cpu_memory_arbiter.sv
// Two-requester arbiter for port A of the Chip-8 CPU memory. Each access runs IDLE -> ISSUE -> CAPTURE,
// returns read data with a one-cycle ack, and flags writes into the protected charset region.
module cpu_memory_arbiter #(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int PROT_TOP   = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_req,
  input  logic        r0_write,
  input  logic [11:0] r0_addr,
  input  logic [7:0]  r0_wdata,
  output logic        r0_ack,
  output logic [7:0]  r0_rdata,
  input  logic        r1_req,
  input  logic        r1_write,
  input  logic [11:0] r1_addr,
  input  logic [7:0]  r1_wdata,
  output logic        r1_ack,
  output logic [7:0]  r1_rdata,
  output logic        mem_en,
  output logic        mem_write,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_in,
  input  logic [7:0]  mem_out,
  output logic        wp_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t      state, state_d;
  logic        gnt, gnt_d;
  logic        last_grant, last_grant_d;
  logic        is_write, is_write_d;
  logic        pick_r1;
  logic        mem_en_d, mem_write_d, wp_err_d, busy_d;
  logic        r0_ack_d, r1_ack_d;
  logic [11:0] mem_addr_d;
  logic [7:0]  mem_in_d, r0_rdata_d, r1_rdata_d;

  // Tie-break: fixed priority favours r1; round-robin favours whoever was not granted last.
  assign pick_r1 = r1_req && (!r0_req || FIXED_PRIO || !last_grant);

  always_comb begin
    state_d      = state;
    gnt_d        = gnt;
    last_grant_d = last_grant;
    is_write_d   = is_write;
    mem_en_d     = 1'b0;
    mem_write_d  = 1'b0;
    mem_addr_d   = mem_addr;
    mem_in_d     = mem_in;
    wp_err_d     = 1'b0;
    r0_ack_d     = 1'b0;
    r1_ack_d     = 1'b0;
    r0_rdata_d   = r0_rdata;
    r1_rdata_d   = r1_rdata;
    case (state)
      IDLE: begin
        if (r0_req || r1_req) begin
          gnt_d        = pick_r1;
          last_grant_d = pick_r1;
          is_write_d   = pick_r1 ? r1_write : r0_write;
          mem_en_d     = 1'b1;
          mem_write_d  = pick_r1 ? r1_write : r0_write;
          mem_addr_d   = pick_r1 ? r1_addr  : r0_addr;
          mem_in_d     = pick_r1 ? r1_wdata : r0_wdata;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        // The write still goes out; the memory itself ignores it.
        wp_err_d = mem_write && (mem_addr[11:PROT_TOP] == '0);
        state_d  = CAPTURE;
      end
      CAPTURE: begin
        if (gnt) begin
          r1_ack_d = 1'b1;
          if (!is_write) r1_rdata_d = mem_out;
        end else begin
          r0_ack_d = 1'b1;
          if (!is_write) r0_rdata_d = mem_out;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // last_grant resets to 1 so requester 0 takes the first contested grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      is_write   <= 1'b0;
      mem_en     <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_in     <= '0;
      wp_err     <= 1'b0;
      busy       <= 1'b0;
      r0_ack     <= 1'b0;
      r1_ack     <= 1'b0;
      r0_rdata   <= '0;
      r1_rdata   <= '0;
    end else begin
      state      <= state_d;
      gnt        <= gnt_d;
      last_grant <= last_grant_d;
      is_write   <= is_write_d;
      mem_en     <= mem_en_d;
      mem_write  <= mem_write_d;
      mem_addr   <= mem_addr_d;
      mem_in     <= mem_in_d;
      wp_err     <= wp_err_d;
      busy       <= busy_d;
      r0_ack     <= r0_ack_d;
      r1_ack     <= r1_ack_d;
      r0_rdata   <= r0_rdata_d;
      r1_rdata   <= r1_rdata_d;
    end
  end

endmodule

// File: tb/tb_cpu_memory_arbiter.sv
// Directed bench for cpu_memory_arbiter: a round-robin instance on a small memory model with a
// protected charset region, plus a fixed-priority instance for the priority scenario.
module tb_cpu_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        r0_req = 0, r0_write = 0, r1_req = 0, r1_write = 0;
  logic [11:0] r0_addr = 0, r1_addr = 0;
  logic [7:0]  r0_wdata = 0, r1_wdata = 0;
  logic        r0_ack, r1_ack, mem_en, mem_write, wp_err, busy;
  logic [7:0]  r0_rdata, r1_rdata, mem_in;
  logic [7:0]  mem_out = 0;
  logic [11:0] mem_addr;

  logic        b_r0_req = 0, b_r1_req = 0;
  logic [11:0] b_r0_addr = 0, b_r1_addr = 0;
  logic        b_r0_ack, b_r1_ack, b_mem_en, b_mem_write, b_wp_err, b_busy;
  logic [7:0]  b_r0_rdata, b_r1_rdata, b_mem_in;
  logic [7:0]  b_mem_out = 0;
  logic [11:0] b_mem_addr;

  logic [7:0]  mem_a [4096];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cpu_memory_arbiter #(.FIXED_PRIO(1'b0), .PROT_TOP(9)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .mem_en(mem_en), .mem_write(mem_write), .mem_addr(mem_addr), .mem_in(mem_in),
    .mem_out(mem_out), .wp_err(wp_err), .busy(busy)
  );

  cpu_memory_arbiter #(.FIXED_PRIO(1'b1), .PROT_TOP(9)) dut_fixed (
    .clk(clk), .reset(reset),
    .r0_req(b_r0_req), .r0_write(1'b0), .r0_addr(b_r0_addr), .r0_wdata(8'h00),
    .r0_ack(b_r0_ack), .r0_rdata(b_r0_rdata),
    .r1_req(b_r1_req), .r1_write(1'b0), .r1_addr(b_r1_addr), .r1_wdata(8'h00),
    .r1_ack(b_r1_ack), .r1_rdata(b_r1_rdata),
    .mem_en(b_mem_en), .mem_write(b_mem_write), .mem_addr(b_mem_addr), .mem_in(b_mem_in),
    .mem_out(b_mem_out), .wp_err(b_wp_err), .busy(b_busy)
  );

  // Registered-read memory; the charset region below 0x200 ignores writes.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_write) begin
        if (mem_addr >= 12'h200) mem_a[mem_addr] <= mem_in;
      end else begin
        mem_out <= mem_a[mem_addr];
      end
    end
  end

  always @(posedge clk) begin
    if (b_mem_en && !b_mem_write) b_mem_out <= b_mem_addr[7:0];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete access on the round-robin instance with fixed-latency checks at every stage.
  task automatic apply_stimulus(input logic sel, input logic wr, input logic [11:0] addr,
                                input logic [7:0] wdata, input logic exp_wp,
                                input logic [7:0] exp_rdata, input string tag);
    if (!sel) begin
      r0_req = 1; r0_write = wr; r0_addr = addr; r0_wdata = wdata;
    end else begin
      r1_req = 1; r1_write = wr; r1_addr = addr; r1_wdata = wdata;
    end
    tick();
    check_output({tag, ".issue_en"}, 32'(mem_en), 1);
    check_output({tag, ".issue_wr"}, 32'(mem_write), 32'(wr));
    check_output({tag, ".issue_addr"}, 32'(mem_addr), 32'(addr));
    if (wr) check_output({tag, ".issue_data"}, 32'(mem_in), 32'(wdata));
    check_output({tag, ".busy"}, 32'(busy), 1);
    tick();
    check_output({tag, ".capture_en"}, 32'(mem_en), 0);
    check_output({tag, ".wp_err"}, 32'(wp_err), 32'(exp_wp));
    check_output({tag, ".early_ack"}, 32'({r1_ack, r0_ack}), 0);
    tick();
    check_output({tag, ".ack"}, 32'({r1_ack, r0_ack}), sel ? 2 : 1);
    check_output({tag, ".rdata"}, sel ? 32'(r1_rdata) : 32'(r0_rdata), 32'(exp_rdata));
    check_output({tag, ".wp_clear"}, 32'(wp_err), 0);
    r0_req = 0;
    r1_req = 0;
    tick();
    check_output({tag, ".ack_end"}, 32'({r1_ack, r0_ack}), 0);
    check_output({tag, ".idle"}, 32'(busy), 0);
  endtask

  initial begin
    int n_acks;
    int both_acks;
    logic [3:0] seq;
    int b0_acks;
    int b1_acks;
    int stray;

    for (int i = 0; i < 4096; i++) mem_a[i] = 8'h00;
    mem_a[12'h200] = 8'hA2;
    mem_a[12'h1FF] = 8'h80;

    // Reset state
    tick();
    tick();
    check_output("rst.outs", 32'({mem_en, mem_write, wp_err, busy, r0_ack, r1_ack}), 0);
    check_output("rst.addr", 32'(mem_addr), 0);
    check_output("rst.rdata", 32'({r0_rdata, r1_rdata}), 0);
    check_output("rst.fixed", 32'({b_mem_en, b_busy, b_r0_ack, b_r1_ack}), 0);
    reset = 0;
    tick();

    // Scenario 1: read of 0x200
    apply_stimulus(1'b0, 1'b0, 12'h200, 8'h00, 1'b0, 8'hA2, "t1");

    // Scenario 2: r1 writes 0x300, r0 reads it back; r1_rdata untouched by a write
    apply_stimulus(1'b1, 1'b1, 12'h300, 8'h5C, 1'b0, 8'h00, "t2w");
    apply_stimulus(1'b0, 1'b0, 12'h300, 8'h00, 1'b0, 8'h5C, "t2r");

    // Scenario 3: write into the charset region flags wp_err, font byte survives
    apply_stimulus(1'b1, 1'b1, 12'h1FF, 8'hFF, 1'b1, 8'h00, "t3w");
    apply_stimulus(1'b0, 1'b0, 12'h1FF, 8'h00, 1'b0, 8'h80, "t3r");

    // Scenario 4: round-robin with both requesters held for 12 clocks after reset
    reset = 1;
    tick();
    reset = 0;
    tick();
    r0_req = 1; r0_write = 0; r0_addr = 12'h200;
    r1_req = 1; r1_write = 0; r1_addr = 12'h300;
    n_acks = 0;
    both_acks = 0;
    seq = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (r0_ack && r1_ack) both_acks++;
      if ((r0_ack || r1_ack) && n_acks < 4) seq[n_acks] = r1_ack;
      if (r0_ack || r1_ack) n_acks++;
    end
    r0_req = 0;
    r1_req = 0;
    check_output("t4.ack_count", 32'(n_acks), 4);
    check_output("t4.order", 32'(seq), 32'b1010);
    check_output("t4.both_ack", 32'(both_acks), 0);
    check_output("t4.r0_rdata", 32'(r0_rdata), 32'hA2);
    check_output("t4.r1_rdata", 32'(r1_rdata), 32'h5C);
    tick();
    check_output("t4.idle", 32'({busy, r0_ack, r1_ack}), 0);

    // Scenario 5: fixed priority, r1 always wins until it drops
    b_r0_req = 1; b_r0_addr = 12'h2AB;
    b_r1_req = 1; b_r1_addr = 12'h345;
    b0_acks = 0;
    b1_acks = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (b_r0_ack) b0_acks++;
      if (b_r1_ack) b1_acks++;
    end
    check_output("t5.r0_acks", 32'(b0_acks), 0);
    check_output("t5.r1_acks", 32'(b1_acks), 3);
    check_output("t5.r1_rdata", 32'(b_r1_rdata), 32'h45);
    b_r1_req = 0;
    tick();
    check_output("t5.r0_grant_en", 32'(b_mem_en), 1);
    check_output("t5.r0_grant_addr", 32'(b_mem_addr), 32'h2AB);
    tick();
    tick();
    check_output("t5.r0_ack", 32'({b_r1_ack, b_r0_ack}), 1);
    check_output("t5.r0_rdata", 32'(b_r0_rdata), 32'hAB);
    b_r0_req = 0;
    tick();

    // Scenario 6: reset during ISSUE aborts the access without an ack
    r0_req = 1; r0_write = 0; r0_addr = 12'h200;
    tick();
    check_output("t6.issue_en", 32'(mem_en), 1);
    #1 reset = 1;
    #1;
    check_output("t6.async_drop", 32'({mem_en, busy}), 0);
    r0_req = 0;
    #1 reset = 0;
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (r0_ack || r1_ack || mem_en) stray++;
    end
    check_output("t6.no_ack", 32'(stray), 0);
    check_output("t6.rdata_cleared", 32'(r0_rdata), 0);
    apply_stimulus(1'b0, 1'b0, 12'h200, 8'h00, 1'b0, 8'hA2, "t6r");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
